demux_1to2_4bit_buf: RTL
========================

Name: demux_1to2_4bit_buf

Overview:
- Registered 1-to-2 demultiplexer: the inverse of the team's 2:1 mux datapath.
- Takes one WIDTH-bit stream with valid/ready handshake and steers each accepted word to channel A or channel B.
- Each channel has a one-entry output buffer with its own valid/ready handshake.
- Sits downstream of a muxed/shared bus to split traffic back into per-channel consumers; also keeps per-channel transfer counters.

Parameters:
- WIDTH, 4, data width of input and both outputs.
- CNT_W, 8, width of per-channel accepted-word counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  input word.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept in_data this cycle.
- sel  input  1  destination select: 0 = channel A, 1 = channel B; sampled only on an accept cycle.
- out_a  output  WIDTH  channel A buffered word.
- out_a_valid  output  1  out_a holds an undelivered word.
- out_a_ready  input  1  channel A consumer accepts out_a.
- out_b  output  WIDTH  channel B buffered word.
- out_b_valid  output  1  out_b holds an undelivered word.
- out_b_ready  input  1  channel B consumer accepts out_b.
- count_a  output  CNT_W  words accepted into A since reset.
- count_b  output  CNT_W  words accepted into B since reset.

Behaviour:
- One clock (clk). Reset is synchronous, active-high (rst): sampled on the rising edge of clk only.
- Reset values: out_a=0, out_b=0, out_a_valid=0, out_b_valid=0, count_a=0, count_b=0.
- Reset overrides everything in the same cycle. Any buffered word is discarded. Any transfer attempted in the reset cycle is not accepted and not counted.
- Per-channel state machine, two states:
  - EMPTY (valid=0) -> FULL on fill.
  - FULL (valid=1) -> EMPTY on drain without fill.
  - FULL -> FULL on drain and fill in the same cycle (back-to-back reload).
  - FULL -> FULL with no drain: data held stable.
- Drain of X: out_x_valid & out_x_ready.
- in_ready (combinational):
  - sel=0: ~out_a_valid | out_a_ready.
  - sel=1: ~out_b_valid | out_b_ready.
  - Depends only on the selected channel; the other channel being stalled never blocks.
- Accept: in_valid & in_ready. On an accept edge the selected channel's out_x <= in_data, out_x_valid <= 1, count_x <= count_x + 1. The unselected channel is unaffected.
- Latency: a word accepted at edge N is visible on out_x, with out_x_valid=1, immediately after edge N (1 cycle).
- After a drain with no refill, out_x retains its last value while valid=0. Consumers must ignore data when valid is low.
- Simultaneous events on the same edge: drain of A with accept into B, or accept into A with drain of B, are independent and both take effect.
- Throughput: 1 word/cycle per channel when the consumer holds ready=1.
- Counters wrap modulo 2^CNT_W: 255 + 1 -> 0, no saturation.
- in_data and sel are don't-care when in_valid=0.

Optional Feature:
- Macro: DEMUX_RR_EN.
- Defined:
  - sel is ignored.
  - An internal pointer (reset to 0 = channel A) chooses the destination and toggles after every accepted word.
  - in_ready uses the pointer's channel.
  - Yields strict A,B,A,B round-robin with no skipping: a stalled channel stalls the input.
- Undefined: destination comes from sel as described above; no pointer logic is present.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 -> all outputs 0, in_ready irrelevant, counts stay 0.
- Steer A: sel=0, both readies=1; push 4'h2, 4'h3, 4'h4, 4'h5 on consecutive cycles -> out_a shows 2,3,4,5 one cycle after each push with valid=1 continuously; out_b_valid=0; count_a=4.
- Steer B under backpressure: sel=1, out_b_ready=0; push 4'hd -> out_b=D, valid=1; next push holds with in_ready=0 and out_b=D stable. Raise out_b_ready -> 4'he accepted the same cycle D drains (reload), count_b=2.
- Independence: fill A with 4'h6 and hold out_a_ready=0; sel=1 push 4'hf -> accepted, in_ready=1, out_b=F, out_a stays 6 valid.
- Wrap: 256 accepts into A -> count_a returns to 0. Assert rst while out_a_valid=1 -> valid clears next edge.
- DEMUX_RR_EN build: sel forced to 1; push 4'h7, 4'h8, 4'h9 -> 7 on A, 8 on B, 9 on A; stall A before the 3rd push -> in_ready=0 until A drains.

Source files
------------

// File: rtl/demux_1to2_4bit_buf_if.sv
// Bus bundle for the 1-to-2 demux: one input stream, two buffered output channels,
// and the per-channel accept counters. The slave modport is the demux's view.
interface demux_1to2_4bit_buf_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
);
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic             sel;
   logic [WIDTH-1:0] out_a;
   logic             out_a_valid;
   logic             out_a_ready;
   logic [WIDTH-1:0] out_b;
   logic             out_b_valid;
   logic             out_b_ready;
   logic [CNT_W-1:0] count_a;
   logic [CNT_W-1:0] count_b;

   modport slave (
      input  in_data, in_valid, sel, out_a_ready, out_b_ready,
      output in_ready, out_a, out_a_valid, out_b, out_b_valid, count_a, count_b
   );

   modport master (
      output in_data, in_valid, sel, out_a_ready, out_b_ready,
      input  in_ready, out_a, out_a_valid, out_b, out_b_valid, count_a, count_b
   );
endinterface

// File: rtl/demux_1to2_4bit_buf.sv
// Registered 1-to-2 demux with a one-entry buffer and accept counter per channel.
// Optional macro DEMUX_RR_EN replaces sel with a strict A,B round-robin pointer.
module demux_1to2_4bit_buf #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input logic                   clk,
   input logic                   rst,
   demux_1to2_4bit_buf_if.slave  bus
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

   state_e           st_a_q, st_a_d;
   state_e           st_b_q, st_b_d;
   logic [WIDTH-1:0] data_a_q, data_a_d;
   logic [WIDTH-1:0] data_b_q, data_b_d;
   logic [CNT_W-1:0] count_a_q, count_a_d;
   logic [CNT_W-1:0] count_b_q, count_b_d;

   logic dst_b;
   logic drain_a, drain_b;
   logic accept, fill_a, fill_b;
   logic ready_a, ready_b;

`ifdef DEMUX_RR_EN
   logic ptr_q, ptr_d;

   always_ff @(posedge clk) begin
      if (rst) ptr_q <= 1'b0;
      else     ptr_q <= ptr_d;
   end

   always_comb begin
      dst_b = ptr_q;
      ptr_d = ptr_q ^ accept;
   end
`else
   always_comb dst_b = bus.sel;
`endif

   always_comb begin
      drain_a = (st_a_q == FULL) & bus.out_a_ready;
      drain_b = (st_b_q == FULL) & bus.out_b_ready;
      ready_a = (st_a_q == EMPTY) | bus.out_a_ready;
      ready_b = (st_b_q == EMPTY) | bus.out_b_ready;
      // Readiness looks only at the destination channel, so a stalled sibling never blocks.
      bus.in_ready = dst_b ? ready_b : ready_a;
      accept = bus.in_valid & bus.in_ready;
      fill_a = accept & ~dst_b;
      fill_b = accept & dst_b;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_a_q    <= EMPTY;
         st_b_q    <= EMPTY;
         data_a_q  <= '0;
         data_b_q  <= '0;
         count_a_q <= '0;
         count_b_q <= '0;
      end else begin
         st_a_q    <= st_a_d;
         st_b_q    <= st_b_d;
         data_a_q  <= data_a_d;
         data_b_q  <= data_b_d;
         count_a_q <= count_a_d;
         count_b_q <= count_b_d;
      end
   end

   always_comb begin
      st_a_d = st_a_q;
      unique case (st_a_q)
         EMPTY:   if (fill_a) st_a_d = FULL;
         FULL:    if (drain_a && !fill_a) st_a_d = EMPTY;
         default: st_a_d = EMPTY;
      endcase

      st_b_d = st_b_q;
      unique case (st_b_q)
         EMPTY:   if (fill_b) st_b_d = FULL;
         FULL:    if (drain_b && !fill_b) st_b_d = EMPTY;
         default: st_b_d = EMPTY;
      endcase

      // Data is only written on fill; after a drain it lingers with valid low.
      data_a_d  = fill_a ? bus.in_data : data_a_q;
      data_b_d  = fill_b ? bus.in_data : data_b_q;
      count_a_d = count_a_q + {{(CNT_W-1){1'b0}}, fill_a};
      count_b_d = count_b_q + {{(CNT_W-1){1'b0}}, fill_b};
   end

   always_comb begin
      bus.out_a_valid = (st_a_q == FULL);
      bus.out_b_valid = (st_b_q == FULL);
      bus.out_a       = data_a_q;
      bus.out_b       = data_b_q;
      bus.count_a     = count_a_q;
      bus.count_b     = count_b_q;
   end

endmodule
